// File: rtl/spi_mem_master.sv
`default_nettype none
// ============================================================================
// spi_mem_master: mode-0 SPI initiator, one {addr[6:0], rw, data[7:0]} frame per start
// Rev 1.0 | optional abort/aborted ports enabled by `define SPI_MEM_MASTER_ABORT_EN
// ============================================================================
module spi_mem_master #(
  parameter int CLK_DIV = 25,
  parameter int CS_IDLE = 250
) (
  input  logic       clk,
  input  logic       reset,
`ifdef SPI_MEM_MASTER_ABORT_EN
  input  logic       abort,
  output logic       aborted,
`endif
  input  logic       start,
  input  logic       rw,
  input  logic [6:0] addr,
  input  logic [7:0] wdata,
  output logic       busy,
  output logic       done,
  output logic [7:0] rdata,
  output logic       sclk_pin,
  output logic       cs_pin,
  output logic       mosi_pin,
  input  logic       miso_pin
);

  localparam int PH_W  = $clog2(CLK_DIV);
  localparam int GAP_W = $clog2(CS_IDLE + 1);
  localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(CLK_DIV - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(CS_IDLE - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SHIFT = 3'd1,
    HOLD  = 3'd2,
    GAP   = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t            state;
  logic [PH_W-1:0]   phase;
  logic              high_half;
  logic [3:0]        slot;
  logic [GAP_W-1:0]  gap_cnt;
  logic [15:0]       tx_sr;
  logic [7:0]        rx_sr;
  logic              is_read;
  logic              abort_seen;
  logic              abort_hit;
  logic [15:0]       frame;

  assign frame = {addr, rw, (rw ? 8'h00 : wdata)};

`ifdef SPI_MEM_MASTER_ABORT_EN
  assign abort_hit = abort && ((state == SHIFT) || (state == HOLD));
  assign aborted   = abort_seen;
`else
  assign abort_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      phase      <= '0;
      high_half  <= 1'b0;
      slot       <= 4'd0;
      gap_cnt    <= '0;
      tx_sr      <= 16'h0000;
      rx_sr      <= 8'h00;
      is_read    <= 1'b0;
      abort_seen <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      rdata      <= 8'h00;
      sclk_pin   <= 1'b0;
      cs_pin     <= 1'b1;
      mosi_pin   <= 1'b0;
    end else if (abort_hit) begin
      // Drop the bus immediately and still honour the full chip-select gap.
      state      <= GAP;
      gap_cnt    <= '0;
      abort_seen <= 1'b1;
      sclk_pin   <= 1'b0;
      cs_pin     <= 1'b1;
      mosi_pin   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            state      <= SHIFT;
            phase      <= '0;
            high_half  <= 1'b0;
            slot       <= 4'd0;
            is_read    <= rw;
            abort_seen <= 1'b0;
            busy       <= 1'b1;
            cs_pin     <= 1'b0;
            sclk_pin   <= 1'b0;
            mosi_pin   <= frame[15];
            tx_sr      <= {frame[14:0], 1'b0};
          end
        end

        SHIFT: begin
          if (phase == PH_LAST) begin
            phase <= '0;
            if (!high_half) begin
              high_half <= 1'b1;
              sclk_pin  <= 1'b1;
            end else begin
              // End of a high phase: sample, fall, and present the next bit.
              high_half <= 1'b0;
              sclk_pin  <= 1'b0;
              mosi_pin  <= tx_sr[15];
              tx_sr     <= {tx_sr[14:0], 1'b0};
              if (slot[3]) begin
                rx_sr <= {rx_sr[6:0], miso_pin};
              end
              slot <= slot + 4'd1;
              if (slot == 4'd15) begin
                state <= HOLD;
              end
            end
          end else begin
            phase <= phase + 1'b1;
          end
        end

        HOLD: begin
          if (phase == PH_LAST) begin
            phase    <= '0;
            gap_cnt  <= '0;
            cs_pin   <= 1'b1;
            mosi_pin <= 1'b0;
            state    <= GAP;
          end else begin
            phase <= phase + 1'b1;
          end
        end

        GAP: begin
          if (gap_cnt == GAP_LAST) begin
            state <= DONE;
            done  <= 1'b1;
            busy  <= 1'b0;
            if (is_read && !abort_seen) begin
              rdata <= rx_sr;
            end
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end

        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          state    <= IDLE;
          busy     <= 1'b0;
          done     <= 1'b0;
          cs_pin   <= 1'b1;
          sclk_pin <= 1'b0;
          mosi_pin <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_spi_mem_master.sv
`default_nettype none
// tb_spi_mem_master: default and minimum-parameter masters, each driving a behavioural SPI memory slave.
module tb_spi_mem_master;

  localparam int D0 = 25;
  localparam int C0 = 250;
  localparam int D1 = 2;
  localparam int C1 = 1;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rw = 1'b0;
  logic [6:0] addr = 7'h00;
  logic [7:0] wdata = 8'h00;
  logic [1:0] start_v = 2'b00;
  wire  [1:0] busy_v, done_v, sclk_v, cs_v, mosi_v;
  wire  [7:0] rdata0, rdata1;
  wire        miso0, miso1;

  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0] ref_mem [2][128];
  logic [7:0] exp_rdata [2];

`ifdef SPI_MEM_MASTER_ABORT_EN
  logic abort0 = 1'b0;
  wire  aborted0, aborted1;
`endif

  always #5 clk = ~clk;

  function automatic logic [7:0] init_val(input int g, input int i);
    if (g == 1 && i == 12) return 8'h0F;
    return 8'((i * 37 + g * 11 + 5) & 255);
  endfunction

  spi_mem_master #(.CLK_DIV(D0), .CS_IDLE(C0)) u_dut0 (
    .clk(clk), .reset(reset),
`ifdef SPI_MEM_MASTER_ABORT_EN
    .abort(abort0), .aborted(aborted0),
`endif
    .start(start_v[0]), .rw(rw), .addr(addr), .wdata(wdata),
    .busy(busy_v[0]), .done(done_v[0]), .rdata(rdata0),
    .sclk_pin(sclk_v[0]), .cs_pin(cs_v[0]), .mosi_pin(mosi_v[0]), .miso_pin(miso0)
  );

  spi_mem_master #(.CLK_DIV(D1), .CS_IDLE(C1)) u_dut1 (
    .clk(clk), .reset(reset),
`ifdef SPI_MEM_MASTER_ABORT_EN
    .abort(1'b0), .aborted(aborted1),
`endif
    .start(start_v[1]), .rw(rw), .addr(addr), .wdata(wdata),
    .busy(busy_v[1]), .done(done_v[1]), .rdata(rdata1),
    .sclk_pin(sclk_v[1]), .cs_pin(cs_v[1]), .mosi_pin(mosi_v[1]), .miso_pin(miso1)
  );

  // Slave: shifts MOSI in on SCLK rise, drives MISO on SCLK fall, commits writes only on full frames.
  for (genvar g = 0; g < 2; g++) begin : g_slave
    logic [7:0]  mem [128];
    logic [15:0] sh = 16'h0000;
    logic [15:0] last_frame = 16'h0000;
    int          nb = 0;
    logic [7:0]  rd_sh = 8'h00;
    logic        rd_mode = 1'b0;
    logic        miso_r = 1'b0;

    initial for (int i = 0; i < 128; i++) mem[i] = init_val(g, i);

    always @(posedge sclk_v[g] or posedge cs_v[g]) begin
      if (cs_v[g]) begin
        if (nb == 16 && !sh[8]) mem[sh[15:9]] = sh[7:0];
        if (nb != 0) last_frame = sh;
        nb = 0;
        sh = 16'h0000;
      end else begin
        sh = {sh[14:0], mosi_v[g]};
        nb++;
      end
    end

    always @(negedge sclk_v[g]) begin
      if (!cs_v[g]) begin
        if (nb == 8) begin
          rd_mode = sh[0];
          rd_sh   = mem[sh[7:1]];
        end
        if (nb >= 8 && nb < 16) begin
          miso_r = rd_mode & rd_sh[7];
          rd_sh  = {rd_sh[6:0], 1'b0};
        end else begin
          miso_r = 1'b0;
        end
      end
    end
  end

  assign miso0 = g_slave[0].miso_r;
  assign miso1 = g_slave[1].miso_r;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge of cycle 1 after acceptance.
  task automatic drive_start(input int sel, input logic r, input logic [6:0] a, input logic [7:0] wd);
    rw = r;
    addr = a;
    wdata = wd;
    start_v[sel] = 1'b1;
    @(negedge clk);
    start_v[sel] = 1'b0;
  endtask

  task automatic run_txn(input int sel, input logic r, input logic [6:0] a, input logic [7:0] wd);
    int dv = (sel == 1) ? D1 : D0;
    int ci = (sel == 1) ? C1 : C0;
    int n = 1;
    int done_at = -1;
    int cs_low = 0;
    logic [15:0] frame;
    logic [7:0]  rd;
    drive_start(sel, r, a, wd);
    check("cycle1_busy", 32'(busy_v[sel]), 32'd1);
    check("cycle1_cs", 32'(cs_v[sel]), 32'd0);
    check("cycle1_mosi", 32'(mosi_v[sel]), 32'(a[6]));
    while (n < 3000) begin
      if (!cs_v[sel]) cs_low++;
      if (done_v[sel]) begin
        done_at = n;
        break;
      end
      @(negedge clk);
      n++;
    end
    check("done_cycle", done_at, 1 + 33 * dv + ci);
    check("cs_low_len", cs_low, 33 * dv);
    frame = (sel == 1) ? g_slave[1].last_frame : g_slave[0].last_frame;
    check("mosi_frame", 32'(frame), 32'({a, r, (r ? 8'h00 : wd)}));
    if (r) exp_rdata[sel] = ref_mem[sel][a];
    else   ref_mem[sel][a] = wd;
    rd = (sel == 1) ? rdata1 : rdata0;
    check("rdata_at_done", 32'(rd), 32'(exp_rdata[sel]));
    @(negedge clk);
    check("done_one_cycle", 32'(done_v[sel]), 32'd0);
    check("busy_after_done", 32'(busy_v[sel]), 32'd0);
  endtask

  initial begin
    int n;
    int dones;
    int first;
    for (int g = 0; g < 2; g++) begin
      exp_rdata[g] = 8'h00;
      for (int i = 0; i < 128; i++) ref_mem[g][i] = init_val(g, i);
    end

    repeat (3) @(negedge clk);
    check("rst_cs", 32'(cs_v), 32'b11);
    check("rst_sclk", 32'(sclk_v), 32'b00);
    check("rst_mosi", 32'(mosi_v), 32'b00);
    check("rst_busy", 32'(busy_v), 32'b00);
    check("rst_done", 32'(done_v), 32'b00);
    check("rst_rdata0", 32'(rdata0), 32'h00);
    check("rst_rdata1", 32'(rdata1), 32'h00);
    reset = 1'b0;
    @(negedge clk);

    // Directed write/read/write with defaults.
    run_txn(0, 1'b0, 7'h04, 8'hF0);
    check("slave_mem_04", 32'(g_slave[0].mem[4]), 32'hF0);
    run_txn(0, 1'b1, 7'h04, 8'h00);
    check("read_04", 32'(rdata0), 32'hF0);
    run_txn(0, 1'b0, 7'h10, 8'h33);
    check("rdata_held", 32'(rdata0), 32'hF0);

`ifdef SPI_MEM_MASTER_ABORT_EN
    drive_start(0, 1'b0, 7'h04, 8'h00);
    n = 1;
    repeat (24 * D0 + 3) begin
      @(negedge clk);
      n++;
    end
    first = n;
    abort0 = 1'b1;
    @(negedge clk);
    n++;
    abort0 = 1'b0;
    check("abort_cs", 32'(cs_v[0]), 32'd1);
    check("abort_sclk", 32'(sclk_v[0]), 32'd0);
    check("abort_mosi", 32'(mosi_v[0]), 32'd0);
    dones = -1;
    while (n < 3000) begin
      if (done_v[0]) begin
        dones = n;
        break;
      end
      @(negedge clk);
      n++;
    end
    check("abort_done_cycle", dones, first + 1 + C0);
    check("aborted_flag", 32'(aborted0), 32'd1);
    check("abort_rdata", 32'(rdata0), 32'(exp_rdata[0]));
    @(negedge clk);
    run_txn(0, 1'b1, 7'h04, 8'h00);
    check("read_after_abort", 32'(rdata0), 32'hF0);
    check("aborted_cleared", 32'(aborted0), 32'd0);
`endif

    // Start pulses while busy must be dropped.
    drive_start(0, 1'b0, 7'h21, 8'hA5);
    n = 1;
    dones = 0;
    first = -1;
    while (n < 1300) begin
      if (done_v[0]) begin
        dones++;
        if (first < 0) first = n;
      end
      if (n == 5 || n == 600) begin
        addr = 7'h5E;
        wdata = 8'h3C;
        start_v[0] = 1'b1;
      end else begin
        start_v[0] = 1'b0;
      end
      @(negedge clk);
      n++;
    end
    start_v[0] = 1'b0;
    check("busy_start_dones", dones, 1);
    check("busy_start_done_cyc", first, 1 + 33 * D0 + C0);
    check("busy_start_frame", 32'(g_slave[0].last_frame), 32'({7'h21, 1'b0, 8'hA5}));
    ref_mem[0][7'h21] = 8'hA5;

    // Reset in slot 6.
    drive_start(0, 1'b0, 7'h11, 8'h77);
    repeat (12 * D0 + 4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("midrst_cs", 32'(cs_v[0]), 32'd1);
    check("midrst_sclk", 32'(sclk_v[0]), 32'd0);
    check("midrst_busy", 32'(busy_v[0]), 32'd0);
    check("midrst_mosi", 32'(mosi_v[0]), 32'd0);
    reset = 1'b0;
    exp_rdata[0] = 8'h00;
    exp_rdata[1] = 8'h00;
    dones = 0;
    repeat (1200) begin
      @(negedge clk);
      if (done_v[0]) dones++;
    end
    check("midrst_no_done", dones, 0);
    check("midrst_rdata", 32'(rdata0), 32'h00);
    check("midrst_no_write", 32'(g_slave[0].mem[7'h11]), 32'(ref_mem[0][7'h11]));
    run_txn(0, 1'b0, 7'h11, 8'h77);
    run_txn(0, 1'b1, 7'h11, 8'h00);

    // Minimum parameters.
    run_txn(1, 1'b1, 7'h0C, 8'h00);
    check("min_read_0c", 32'(rdata1), 32'h0F);

    // Randomized traffic against the reference memory.
    for (int k = 0; k < 4; k++) begin
      run_txn(0, 1'($urandom_range(0, 1)), 7'($urandom_range(0, 127)), 8'($urandom));
    end
    for (int k = 0; k < 30; k++) begin
      run_txn(1, 1'($urandom_range(0, 1)), 7'($urandom_range(0, 15)), 8'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/spi_mem_master.md
# spi_mem_master

SPI initiator for the team's SPI memory slave. It runs one complete memory transaction per `start` request: chip-select, a 7-bit address, a read/write bit, and 8 data bits, all MSB-first, then chip-select release. It sits between on-chip control logic and the four SPI pins, and it generates the pin timing that the slave expects (mode 0, slave samples MOSI on SCLK rising edge).

## Interface
- `CLK_DIV`, default 25: SCLK half-period in `clk` cycles. At 50 MHz this gives 500 ns. Legal values are ≥ 2.
- `CS_IDLE`, default 250: minimum `cs_pin`-high gap after each transaction, in `clk` cycles. Legal values are ≥ 1.
- `clk` input 1: system clock. All logic is on the rising edge.
- `reset` input 1: synchronous, active-high reset.
- `start` input 1: transaction request. It is sampled only when `busy` = 0.
- `rw` input 1: 1 = read, 0 = write. Captured on an accepted `start`.
- `addr` input 7: memory address. Captured on an accepted `start`.
- `wdata` input 8: write data. Captured on an accepted `start`.
- `busy` output 1: high from the cycle after an accepted `start` through the cycle before `done`.
- `done` output 1: one-cycle pulse when the transaction completes.
- `rdata` output 8: last completed read byte. It holds until the next completed read.
- `sclk_pin` output 1: SPI clock. Idles low.
- `cs_pin` output 1: chip select, active low.
- `mosi_pin` output 1: serial data to the slave.
- `miso_pin` input 1: serial data from the slave.
- `abort` input 1: present only under `SPI_MEM_MASTER_ABORT_EN`.
- `aborted` output 1: present only under `SPI_MEM_MASTER_ABORT_EN`.

## Operation
- **Reset values:** `cs_pin`=1, `sclk_pin`=0, `mosi_pin`=0, `busy`=0, `done`=0, `rdata`=0x00, `aborted`=0, state IDLE.
- **Reset during a transaction:** the same values apply on the next edge. No completion `done` pulse is produced.
- **Frame:** 16 bits, `{addr[6:0], rw, D[7:0]}`, sent MSB first. D is `wdata` for a write and 8'h00 for a read.
- **State IDLE:** an accepted `start` captures the inputs and moves to SHIFT.
- **State SHIFT:** 16 bit slots. Each slot is a low phase of `CLK_DIV` cycles followed by a high phase of `CLK_DIV` cycles.
  - `mosi_pin` changes only on the first cycle of each low phase.
  - On a read, `miso_pin` is sampled on the last cycle of the high phase in slots 8–15 (the data bits). Sampled bits shift in at the LSB.
- **State HOLD:** `sclk_pin` low and `cs_pin` low for `CLK_DIV` cycles.
- **State GAP:** `cs_pin` high, `mosi_pin` 0, for `CS_IDLE` cycles.
- **State DONE:** a single cycle.
  - `done`=1 and `busy`=0 in this cycle.
  - On a read, `rdata` is loaded in this cycle.
  - The next cycle returns to IDLE.
- **`start` while busy:** ignored and not queued.
- **`start` during the DONE cycle:** ignored. A new request is accepted from IDLE only.
- **Slot counter:** a 4-bit slot counter wraps 15→0, and the wrap exits SHIFT.
- **Phase counter:** the half-period counter is sized to hold `CLK_DIV`−1.

## Timing
- Accepted `start` at cycle 0.
  - Cycle 1: `cs_pin` falls, `sclk_pin`=0, `mosi_pin`=`addr[6]`, `busy`=1.
- First SCLK rise at cycle 1+`CLK_DIV`.
- Slot k rises at cycle 1+(2k+1)·`CLK_DIV`.
- Last SCLK fall at cycle 1+32·`CLK_DIV`.
- `cs_pin` rises at cycle 1+33·`CLK_DIV`.
- `done` at cycle 1+33·`CLK_DIV`+`CS_IDLE`. With the defaults this is cycle 1076.
- Back-to-back throughput: the next `start` can be accepted in the cycle after `done`.
- MOSI setup to the SCLK rise is `CLK_DIV` cycles.
- MISO is sampled `CLK_DIV`−1 cycles after the SCLK rise.

## Configuration
- **`SPI_MEM_MASTER_ABORT_EN` defined:** the `abort` input and `aborted` output exist.
  - Trigger: `abort`=1 in SHIFT or HOLD.
  - Next cycle: `cs_pin`=1, `sclk_pin`=0, `mosi_pin`=0, and the block enters GAP.
  - The completion `done` pulse then has `aborted`=1.
  - `rdata` is unchanged.
  - `abort` in IDLE, GAP or DONE is ignored.
  - `aborted` clears on the next accepted `start`.
- **Undefined:** neither port exists, and every transaction runs all 16 slots.

## Test plan
- **Write, defaults:** write addr 0x04, wdata 0xF0.
  - MOSI sampled at the 16 SCLK rises = 0000100_0_11110000.
  - `cs_pin` low for exactly 33·25 cycles.
  - `done` at cycle 1076.
  - Slave model memory[0x04] = 0xF0.
- **Read:** read addr 0x04 with a slave model returning 0xF0.
  - MOSI = 0000100_1_00000000.
  - `rdata` = 0xF0 on the `done` cycle.
  - A following write leaves `rdata` at 0xF0.
- **`start` while busy:** pulse `start` at cycles 5 and 600 with different addr.
  - Exactly one transaction and one `done` pulse occur.
  - Frame carries the cycle-0 addr.
- **Reset mid-transfer:** assert `reset` at slot 6.
  - Next edge: `cs_pin`=1, `sclk_pin`=0, `busy`=0.
  - No `done` pulse.
  - A new write afterwards completes normally.
- **Abort (macro defined):** `abort` during slot 12 of a write of 0x00 to 0x04.
  - `cs_pin` high the next cycle.
  - `done` after `CS_IDLE` cycles with `aborted`=1.
  - A read of 0x04 then returns 0xF0.
- **Minimum parameters:** `CLK_DIV`=2, `CS_IDLE`=1, read of 0x0C returning 0x0F.
  - `rdata`=0x0F.
  - `done` at cycle 68.
